imm_encoder: RTL and testbench
==============================

# imm_encoder

Streaming RV64 instruction encoder: takes decoded fields plus a 64-bit signed immediate, range-checks the immediate for the selected format, and packs a 32-bit instruction word. It is the writer side of the immediate-generation path: it produces the words the core's instruction memory holds, with a byte address per word. A two-stage valid/ready pipeline sits between the test/loader front end and the instruction-memory write port.

## Interface
- Parameters:
- ADDR_W, 64, width of the output byte address
- ERRCNT_W, 16, width of the saturating error counter
- Ports:
- clk_i  in  1  single clock, all state on rising edge
- rst_i  in  1  asynchronous, active-low reset
- in_valid_i  in  1  input fields valid
- in_ready_o  out  1  encoder accepts input this cycle
- fmt_i  in  3  format: R=0, I=1, S=2, B=3, U=4, J=5; 6/7 illegal
- opcode_i  in  7  opcode field
- rd_i, rs1_i, rs2_i  in  5 each  register fields
- funct3_i  in  3  funct3
- funct7_i  in  7  funct7 (R only)
- imm_i  in  64  signed immediate, byte units
- out_valid_o  out  1  instr_o/addr_o/err_o valid
- out_ready_i  in  1  downstream accepts word
- instr_o  out  32  packed instruction
- addr_o  out  ADDR_W  byte address of instr_o
- err_o  out  1  immediate not representable / illegal fmt for this word
- err_cnt_o  out  ERRCNT_W  saturating count of emitted words with err_o=1

## Operation
- Stage 1 (check): on in_valid_i && in_ready_o, register fields; compute err.
- Range rules: I, S: imm_i == sext(imm_i[11:0]). B: imm_i[0]==0 and imm_i == sext(imm_i[12:0]). J: imm_i[0]==0 and imm_i == sext(imm_i[20:0]). U: imm_i[11:0]==0 and imm_i == sext(imm_i[31:0]). R: imm ignored, never errs.
- Stage 2 (pack), bits MSB..LSB:
- R: funct7, rs2, rs1, funct3, rd, opcode. I: imm[11:0], rs1, funct3, rd, opcode.
- S: imm[11:5], rs2, rs1, funct3, imm[4:0], opcode.
- B: imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode.
- U: imm[31:12], rd, opcode. J: imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode.
- Range error: word still packed from truncated bits; err_o=1.
- Illegal fmt: instr_o = 32'h00000013 (nop), err_o=1.
- Address counter: starts at 0; addr_o is the counter value; +4 on each output handshake (out_valid_o && out_ready_i); wraps modulo 2^ADDR_W.
- err_cnt_o: +1 on each output handshake with err_o=1; saturates at all-ones.

## Timing
- Reset (rst_i low, any time, async): both stage valids 0, out_valid_o=0, instr_o=0, addr_o=0, err_o=0, err_cnt_o=0. In-flight words discarded.
- Latency: input accepted in cycle N appears on out_valid_o in cycle N+2 with no backpressure; throughput 1 word/cycle.
- Ready: s2_ready = !s2_valid || out_ready_i; s1_ready = !s1_valid || s2_ready; in_ready_o = s1_ready (combinational from out_ready_i).
- Output holds instr_o/addr_o/err_o stable while out_valid_o && !out_ready_i.
- Full: both stages valid and out_ready_i=0 -> in_ready_o=0; at most 2 words buffered.
- Simultaneous accept and emit in the same cycle: both happen, no bubble, order preserved.
- out_valid_o never depends combinationally on in_valid_i.

## Structure
- Shared package: fmt encodings (FMT_R..FMT_J), NOP constant 32'h00000013, opcode constants for benches.
- One natural sub-module: imm_range_chk (combinational fmt+imm -> err), instantiated in stage 1.

## Test plan
- I: fmt=1, opcode=0x13, rd=1, rs1=0, funct3=0, imm=5 -> instr_o=0x00500093, addr_o=0, err_o=0, two cycles after accept.
- S then B back-to-back: sw x2,8(x1) -> 0x0020A423 at addr 0; beq x0,x0,imm=-4 -> 0xFE000EE3 at addr 4.
- U/J: lui x5, imm=0x12345000 -> 0x123452B7; jal x1, imm=2048 -> 0x001000EF.
- Errors: I with imm=2048 -> instr imm field 0x800, err_o=1; B with imm=3 -> err_o=1; fmt=7 -> 0x00000013, err_o=1; err_cnt_o=3.
- Backpressure: out_ready_i=0, offer 3 inputs -> 2 accepted, in_ready_o=0; release -> words in order at addr 0,4,8, stable while stalled.
- Reset mid-stream: assert rst_i with 2 words buffered -> out_valid_o=0 immediately; next word after release at addr 0, err_cnt_o=0.

Source files
------------

// File: rtl/imm_encoder_pkg.sv
// Shared definitions for the RV64 instruction encoder: format codes, the
// canonical nop and a handful of base opcodes used by loaders and benches.
package imm_encoder_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    localparam logic [6:0] OP_OP     = 7'h33;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_JAL    = 7'h6f;

endpackage

// File: rtl/imm_encoder_if.sv
// Encoder bus: decoded-field input stream and packed-word output stream.
// Both streams use valid/ready: a transfer happens on a rising edge where valid
// and ready are both high; once raised, valid and its payload hold until that edge.
interface imm_encoder_if #(
    parameter int ADDR_W   = 64,
    parameter int ERRCNT_W = 16
);
    logic                in_valid_i;
    logic                in_ready_o;
    logic [2:0]          fmt_i;
    logic [6:0]          opcode_i;
    logic [4:0]          rd_i;
    logic [4:0]          rs1_i;
    logic [4:0]          rs2_i;
    logic [2:0]          funct3_i;
    logic [6:0]          funct7_i;
    logic [63:0]         imm_i;
    logic                out_valid_o;
    logic                out_ready_i;
    logic [31:0]         instr_o;
    logic [ADDR_W-1:0]   addr_o;
    logic                err_o;
    logic [ERRCNT_W-1:0] err_cnt_o;

    modport slave (
        input  in_valid_i, fmt_i, opcode_i, rd_i, rs1_i, rs2_i, funct3_i,
               funct7_i, imm_i, out_ready_i,
        output in_ready_o, out_valid_o, instr_o, addr_o, err_o, err_cnt_o
    );

    modport master (
        output in_valid_i, fmt_i, opcode_i, rd_i, rs1_i, rs2_i, funct3_i,
               funct7_i, imm_i, out_ready_i,
        input  in_ready_o, out_valid_o, instr_o, addr_o, err_o, err_cnt_o
    );
endinterface

// File: rtl/imm_encoder_range_chk.sv
// Combinational check: is the immediate representable in the selected format?
// Illegal format codes always flag an error; R-type ignores the immediate.
module imm_range_chk
    import imm_encoder_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [63:0] imm,
    output logic        err
);
    logic fits_12, fits_13, fits_21, fits_32;

    // Representable iff sign-extending the low bits reproduces the full value.
    assign fits_12 = (imm == {{52{imm[11]}}, imm[11:0]});
    assign fits_13 = (imm == {{51{imm[12]}}, imm[12:0]});
    assign fits_21 = (imm == {{43{imm[20]}}, imm[20:0]});
    assign fits_32 = (imm == {{32{imm[31]}}, imm[31:0]});

    always_comb begin
        err = 1'b1;
        case (fmt)
            FMT_R:        err = 1'b0;
            FMT_I, FMT_S: err = !fits_12;
            FMT_B:        err = imm[0] || !fits_13;
            FMT_U:        err = (imm[11:0] != 12'd0) || !fits_32;
            FMT_J:        err = imm[0] || !fits_21;
            default:      err = 1'b1;
        endcase
    end
endmodule

// File: rtl/imm_encoder.sv
// Two-stage encoder: stage 1 registers fields and the range verdict, stage 2
// holds the packed word; the output stage owns the byte address and error count.
module imm_encoder
    import imm_encoder_pkg::*;
#(
    parameter int ADDR_W   = 64,
    parameter int ERRCNT_W = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    imm_encoder_if.slave  bus
);
    logic               s1_valid;
    logic [2:0]         s1_fmt;
    logic [6:0]         s1_opcode;
    logic [4:0]         s1_rd, s1_rs1, s1_rs2;
    logic [2:0]         s1_funct3;
    logic [6:0]         s1_funct7;
    logic [31:0]        s1_imm;
    logic               s1_err;

    logic               s2_valid;
    logic [31:0]        s2_instr;
    logic               s2_err;

    logic [ADDR_W-1:0]   addr_q;
    logic [ERRCNT_W-1:0] err_cnt_q;

    logic               s1_ready, s2_ready, out_fire, chk_err;
    logic [31:0]        pack_word;

    assign s2_ready        = !s2_valid || bus.out_ready_i;
    assign s1_ready        = !s1_valid || s2_ready;
    assign out_fire        = s2_valid && bus.out_ready_i;

    assign bus.in_ready_o  = s1_ready;
    assign bus.out_valid_o = s2_valid;
    assign bus.instr_o     = s2_instr;
    assign bus.err_o       = s2_err;
    assign bus.addr_o      = addr_q;
    assign bus.err_cnt_o   = err_cnt_q;

    imm_range_chk u_range_chk (
        .fmt (bus.fmt_i),
        .imm (bus.imm_i),
        .err (chk_err)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            s1_valid  <= 1'b0;
            s1_fmt    <= 3'd0;
            s1_opcode <= 7'd0;
            s1_rd     <= 5'd0;
            s1_rs1    <= 5'd0;
            s1_rs2    <= 5'd0;
            s1_funct3 <= 3'd0;
            s1_funct7 <= 7'd0;
            s1_imm    <= 32'd0;
            s1_err    <= 1'b0;
        end else if (s1_ready) begin
            s1_valid <= bus.in_valid_i;
            if (bus.in_valid_i) begin
                s1_fmt    <= bus.fmt_i;
                s1_opcode <= bus.opcode_i;
                s1_rd     <= bus.rd_i;
                s1_rs1    <= bus.rs1_i;
                s1_rs2    <= bus.rs2_i;
                s1_funct3 <= bus.funct3_i;
                s1_funct7 <= bus.funct7_i;
                s1_imm    <= bus.imm_i[31:0];
                s1_err    <= chk_err;
            end
        end
    end

    // Out-of-range immediates still pack their truncated bits; only illegal
    // format codes fall back to the nop word.
    always_comb begin
        pack_word = NOP_WORD;
        case (s1_fmt)
            FMT_R: pack_word = {s1_funct7, s1_rs2, s1_rs1, s1_funct3, s1_rd, s1_opcode};
            FMT_I: pack_word = {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
            FMT_S: pack_word = {s1_imm[11:5], s1_rs2, s1_rs1, s1_funct3,
                                s1_imm[4:0], s1_opcode};
            FMT_B: pack_word = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_funct3,
                                s1_imm[4:1], s1_imm[11], s1_opcode};
            FMT_U: pack_word = {s1_imm[31:12], s1_rd, s1_opcode};
            FMT_J: pack_word = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12],
                                s1_rd, s1_opcode};
            default: pack_word = NOP_WORD;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            s2_valid <= 1'b0;
            s2_instr <= 32'd0;
            s2_err   <= 1'b0;
        end else if (s2_ready) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_instr <= pack_word;
                s2_err   <= s1_err;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            addr_q    <= '0;
            err_cnt_q <= '0;
        end else if (out_fire) begin
            addr_q <= addr_q + ADDR_W'(4);
            if (s2_err && (err_cnt_q != '1))
                err_cnt_q <= err_cnt_q + ERRCNT_W'(1);
        end
    end
endmodule

// File: tb/tb_imm_encoder.sv
// Randomised and directed bench for imm_encoder against a field-arithmetic
// reference model with an in-order expected-word queue.
module tb_imm_encoder;
    import imm_encoder_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   rand_bp  = 1'b0;

    logic [32:0]  exp_q[$];
    logic [63:0]  exp_addr   = 64'd0;
    logic [15:0]  exp_errcnt = 16'd0;

    imm_encoder_if #(.ADDR_W(64), .ERRCNT_W(16)) bus ();

    imm_encoder #(.ADDR_W(64), .ERRCNT_W(16)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: expected {err, word} from the format's field layout.
    function automatic logic [32:0] ref_word(input logic [2:0] fmt, input logic [6:0] op,
                                             input logic [4:0] rd, input logic [4:0] rs1,
                                             input logic [4:0] rs2, input logic [2:0] f3,
                                             input logic [6:0] f7, input longint imm);
        longint unsigned u = imm;
        longint unsigned w;
        longint unsigned base_rs = (64'(rs1) << 15) | (64'(f3) << 12);
        bit err;
        case (fmt)
            3'd0: begin
                err = 0;
                w = (64'(f7) << 25) | (64'(rs2) << 20) | base_rs | (64'(rd) << 7) | 64'(op);
            end
            3'd1: begin
                err = (imm < -2048) || (imm > 2047);
                w = ((u & 64'hfff) << 20) | base_rs | (64'(rd) << 7) | 64'(op);
            end
            3'd2: begin
                err = (imm < -2048) || (imm > 2047);
                w = (((u >> 5) & 64'h7f) << 25) | (64'(rs2) << 20) | base_rs
                    | ((u & 64'h1f) << 7) | 64'(op);
            end
            3'd3: begin
                err = (u[0] == 1'b1) || (imm < -4096) || (imm > 4095);
                w = (((u >> 12) & 1) << 31) | (((u >> 5) & 64'h3f) << 25) | (64'(rs2) << 20)
                    | base_rs | (((u >> 1) & 64'hf) << 8) | (((u >> 11) & 1) << 7) | 64'(op);
            end
            3'd4: begin
                err = ((u & 64'hfff) != 0) || (imm < -64'sd2147483648) || (imm > 64'sd2147483647);
                w = (((u >> 12) & 64'hfffff) << 12) | (64'(rd) << 7) | 64'(op);
            end
            3'd5: begin
                err = (u[0] == 1'b1) || (imm < -64'sd1048576) || (imm > 64'sd1048575);
                w = (((u >> 20) & 1) << 31) | (((u >> 1) & 64'h3ff) << 21) | (((u >> 11) & 1) << 20)
                    | (((u >> 12) & 64'hff) << 12) | (64'(rd) << 7) | 64'(op);
            end
            default: begin
                err = 1;
                w = 64'h13;
            end
        endcase
        return {err, w[31:0]};
    endfunction

    // driver tasks (called and returning on a falling edge)
    task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input longint imm);
        int n = 0;
        bus.fmt_i = fmt; bus.opcode_i = op; bus.rd_i = rd; bus.rs1_i = rs1;
        bus.rs2_i = rs2; bus.funct3_i = f3; bus.funct7_i = f7; bus.imm_i = imm;
        bus.in_valid_i = 1'b1;
        forever begin
            #1;
            if (bus.in_ready_o) break;
            if (++n > 300) begin
                check("accept_timeout", {63'd0, bus.in_ready_o}, 64'd1);
                @(negedge clk);
                bus.in_valid_i = 1'b0;
                return;
            end
            @(negedge clk);
        end
        exp_q.push_back(ref_word(fmt, op, rd, rs1, rs2, f3, f7, imm));
        @(posedge clk);
        @(negedge clk);
        bus.in_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        for (n = 0; n < 500; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        if (n == 500) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic apply_reset();
        #3;
        rst_n = 1'b0;
        exp_q.delete();
        exp_addr   = 64'd0;
        exp_errcnt = 16'd0;
        #1;
        check("rst_out_valid", {63'd0, bus.out_valid_o}, 64'd0);
        check("rst_instr", {32'd0, bus.instr_o}, 64'd0);
        check("rst_addr", bus.addr_o, 64'd0);
        check("rst_err", {63'd0, bus.err_o}, 64'd0);
        check("rst_err_cnt", {48'd0, bus.err_cnt_o}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // scoreboard: every cycle with out_valid compares against the queue head,
    // which also proves the word holds steady while stalled
    initial begin
        logic [32:0] head;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && bus.out_valid_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", {63'd0, bus.out_valid_o}, 64'd0);
                end else begin
                    head = exp_q[0];
                    check("instr", {32'd0, bus.instr_o}, {32'd0, head[31:0]});
                    check("err", {63'd0, bus.err_o}, {63'd0, head[32]});
                    check("addr", bus.addr_o, exp_addr);
                    check("err_cnt", {48'd0, bus.err_cnt_o}, {48'd0, exp_errcnt});
                    if (bus.out_ready_i) begin
                        head = exp_q.pop_front();
                        exp_addr = exp_addr + 64'd4;
                        if (head[32] && exp_errcnt != 16'hffff) exp_errcnt++;
                    end
                end
            end
        end
    end

    // random backpressure
    initial begin
        forever begin
            @(negedge clk);
            if (rand_bp) bus.out_ready_i = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        logic [2:0] fmt;
        longint imm;
        rst_n = 1'b0;
        bus.in_valid_i = 0; bus.out_ready_i = 1; bus.fmt_i = 0; bus.opcode_i = 0;
        bus.rd_i = 0; bus.rs1_i = 0; bus.rs2_i = 0; bus.funct3_i = 0; bus.funct7_i = 0;
        bus.imm_i = 0;
        @(negedge clk);
        apply_reset();

        // addi x1, x0, 5 with latency check
        send(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'sd5);
        #2 check("lat_n1_valid", {63'd0, bus.out_valid_o}, 64'd0);
        @(negedge clk);
        #2 check("lat_n2_valid", {63'd0, bus.out_valid_o}, 64'd1);
        @(negedge clk);
        drain();

        // back-to-back S, B, U, J, R
        send(FMT_S, OP_STORE, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 64'sd8);
        send(FMT_B, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -64'sd4);
        send(FMT_U, OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 64'sh12345000);
        send(FMT_J, OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'sd2048);
        send(FMT_R, OP_OP, 5'd3, 5'd4, 5'd5, 3'd0, 7'h20, 64'sd12345);
        drain();

        // range and format errors
        send(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'sd2048);
        send(FMT_B, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'sd3);
        send(3'd7, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'sd0);
        drain();
        #2 check("err_cnt_after_errors", {48'd0, bus.err_cnt_o}, 64'd3);
        @(negedge clk);

        // backpressure: two words fill the pipe, the third waits
        bus.out_ready_i = 1'b0;
        send(FMT_I, OP_IMM, 5'd7, 5'd8, 5'd0, 3'd1, 7'd0, -64'sd1);
        send(FMT_S, OP_STORE, 5'd0, 5'd9, 5'd10, 3'd3, 7'd0, -64'sd2048);
        bus.fmt_i = FMT_U; bus.opcode_i = OP_LUI; bus.rd_i = 5'd11; bus.imm_i = 64'h7ffff000;
        bus.in_valid_i = 1'b1;
        repeat (3) begin
            #1 check("full_in_ready", {63'd0, bus.in_ready_o}, 64'd0);
            @(negedge clk);
        end
        bus.out_ready_i = 1'b1;
        send(FMT_U, OP_LUI, 5'd11, 5'd0, 5'd0, 3'd0, 7'd0, 64'sh7ffff000);
        drain();

        // reset with two words in flight
        bus.out_ready_i = 1'b0;
        send(FMT_J, OP_JAL, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, -64'sd1048576);
        send(FMT_B, OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd1, 7'd0, 64'sd4095);
        apply_reset();
        bus.out_ready_i = 1'b1;
        send(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'sd5);
        drain();

        // randomised traffic with random backpressure
        rand_bp = 1'b1;
        for (int i = 0; i < 300; i++) begin
            fmt = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 4))
                0: imm = longint'(int'($urandom_range(0, 8191))) - 4096;
                1: imm = longint'(int'($urandom_range(0, 32'h3fffff))) - 64'sh200000;
                2: imm = longint'(int'($urandom()));
                3: imm = {$urandom(), $urandom()};
                default: imm = longint'(int'($urandom() & 32'hfffff000));
            endcase
            if ($urandom_range(0, 1) == 1) imm[0] = 1'b0;
            send(fmt, 7'($urandom_range(0, 127)), 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)), imm);
            if ($urandom_range(0, 7) == 0) @(negedge clk);
        end
        rand_bp = 1'b0;
        @(negedge clk);
        bus.out_ready_i = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
